// File: rtl/snd_bus_pkg.sv
// Shared definitions for the Z80 sound-CPU bus controller.
//   - Address map constants (base/mask pairs and single register addresses)
//   - Wait-state FSM encoding
//   - Decoded-region struct plus the address decode helper
package snd_bus_pkg;

    // Program ROM occupies everything below this address.
    localparam logic [15:0] ROM_LIMIT     = 16'hC000;
    localparam logic [15:0] RAM_BASE      = 16'hC000;
    localparam logic [15:0] RAM_MASK      = 16'hE000;
    localparam logic [15:0] CHIP_BASE     = 16'hE000;
    localparam logic [15:0] CHIP_MASK     = 16'hFC00;
    localparam logic [15:0] REPLY_ADDR    = 16'hF000;
    localparam logic [15:0] CMD_ADDR      = 16'hF002;
    localparam logic [15:0] INT_ACK_ADDR  = 16'hFA00;
    localparam logic [15:0] NMI_CTL_ADDR  = 16'hFC00;

    localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_WAIT,
        WS_HOLD
    } wait_state_t;

    typedef struct packed {
        logic rom;
        logic ram;
        logic chip;
        logic reply;    // F000 write: reply latch
        logic cmd;      // F002 read: command latch
        logic int_ack;  // FA00 write: clears pending command
        logic nmi_ctl;  // FC00 write: NMI enable
    } bus_dec_t;

    // Pure address decode; callers gate with the access qualifier.
    function automatic bus_dec_t decode(input logic [15:0] a);
        bus_dec_t d;
        d.rom     = (a < ROM_LIMIT);
        d.ram     = ((a & RAM_MASK)  == RAM_BASE);
        d.chip    = ((a & CHIP_MASK) == CHIP_BASE);
        d.reply   = (a == REPLY_ADDR);
        d.cmd     = (a == CMD_ADDR);
        d.int_ack = (a == INT_ACK_ADDR);
        d.nmi_ctl = (a == NMI_CTL_ADDR);
        return d;
    endfunction

endpackage

// File: rtl/snd_nmi_timer.sv
// Periodic NMI generator for the sound CPU.
//   CLK, nRESET : clock, async active-low reset
//   nmi_en      : pulses are only started while this is 1
//   nNMI        : active-low NMI, low for NMI_WIDTH cycles per request
// The divider free-runs from NMI_DIV-1 down to 0 regardless of nmi_en, so
// enabling the NMI does not re-phase the period.
module snd_nmi_timer #(
    parameter int unsigned NMI_DIV   = 4096,
    parameter int unsigned NMI_WIDTH = 32
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic nmi_en,
    output logic nNMI
);
    import snd_bus_pkg::*;

    localparam int DIV_W = (NMI_DIV > 2) ? $clog2(NMI_DIV) : 1;
    localparam int PW    = $clog2(NMI_WIDTH + 1);

    logic [DIV_W-1:0] div_q;
    logic [PW-1:0]    pulse_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            div_q   <= DIV_W'(NMI_DIV - 1);
            pulse_q <= '0;
        end else begin
            if (div_q == '0) div_q <= DIV_W'(NMI_DIV - 1);
            else             div_q <= div_q - 1'b1;

            // Enable is only looked at when a pulse starts; dropping it
            // mid-pulse lets the pulse run to completion.
            if (div_q == '0 && nmi_en) pulse_q <= PW'(NMI_WIDTH);
            else if (pulse_q != '0)    pulse_q <= pulse_q - 1'b1;
        end
    end

    assign nNMI = (pulse_q == '0);

endmodule

// File: rtl/snd_bus_ctrl.sv
// Z80 sound-CPU bus controller.
//   CLK, nRESET                 : clock, async active-low reset
//   SDA, SDD_OUT                : Z80 address / write data
//   nMREQ, nRD, nWR             : Z80 strobes (nMREQ already refresh-gated)
//   ROM_DQ, RAM_DQ, CHIP_DQ     : read data sources
//   SDD_MUX                     : read data back to the Z80
//   nROMCS, nRAMCS, nCHIPCS     : active-low selects
//   nWAIT, nINT, nNMI           : Z80 control inputs
//   CMD_WR, CMD_DATA            : main-CPU command write
//   REPLY_DATA, CMD_PENDING     : reply byte and command handshake to main CPU
module snd_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned NMI_DIV     = 4096,
    parameter int unsigned NMI_WIDTH   = 32
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] SDA,
    input  logic [7:0]  SDD_OUT,
    input  logic        nMREQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic [7:0]  ROM_DQ,
    input  logic [7:0]  RAM_DQ,
    input  logic [7:0]  CHIP_DQ,
    output logic [7:0]  SDD_MUX,
    output logic        nROMCS,
    output logic        nRAMCS,
    output logic        nCHIPCS,
    output logic        nWAIT,
    output logic        nINT,
    output logic        nNMI,
    input  logic        CMD_WR,
    input  logic [7:0]  CMD_DATA,
    output logic [7:0]  REPLY_DATA,
    output logic        CMD_PENDING
);
    import snd_bus_pkg::*;

    bus_dec_t    dec;
    logic        acc, acc_q;
    logic        wr_acc, wr_q, wr_stb;
    logic        chip_start;
    logic        nwait_low;
    wait_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q;
    logic [7:0]  cmd_q, reply_q;
    logic        nmi_en_q;

    assign acc    = ~nMREQ & (~nRD | ~nWR);
    assign dec    = decode(SDA);

    // One register write per access: fire only on the first edge that sees
    // the write strobe, however long nWR is held.
    assign wr_acc = acc & ~nWR;
    assign wr_stb = wr_acc & ~wr_q;

    // New 054539 access; also gated by reset so nWAIT releases while the
    // bus is still held during reset (acc_q is forced low then).
    assign chip_start = acc & ~acc_q & dec.chip & nRESET;

    assign nROMCS  = ~(acc & dec.rom);
    assign nRAMCS  = ~(acc & dec.ram);
    assign nCHIPCS = ~(acc & dec.chip);

    always_comb begin
        SDD_MUX = UNMAPPED_DATA;
        if (acc) begin
            if      (dec.rom)  SDD_MUX = ROM_DQ;
            else if (dec.ram)  SDD_MUX = RAM_DQ;
            else if (dec.chip) SDD_MUX = CHIP_DQ;
            else if (dec.cmd)  SDD_MUX = cmd_q;
        end
    end

    // Wait FSM. The entry cycle already drives nWAIT low, so it counts as
    // the first of WAIT_CYCLES; WAIT then lasts until the counter would
    // reach 1, giving exactly WAIT_CYCLES low cycles from the acc rise.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nwait_low = 1'b0;
        case (state_q)
            WS_IDLE: begin
                if (chip_start) begin
                    nwait_low = 1'b1;
                    if (WAIT_CYCLES <= 1) begin
                        state_d = WS_HOLD;
                    end else begin
                        state_d = WS_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WS_WAIT: begin
                if (!acc) begin
                    // Aborted access: release immediately.
                    state_d = WS_IDLE;
                end else begin
                    nwait_low = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                    if (cnt_q == 4'd2) state_d = WS_HOLD;
                end
            end
            WS_HOLD: begin
                if (!acc) state_d = WS_IDLE;
            end
            default: state_d = WS_IDLE;
        endcase
    end

    assign nWAIT = ~(nwait_low & nRESET);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= WS_IDLE;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            wr_q     <= 1'b0;
            pend_q   <= 1'b0;
            cmd_q    <= '0;
            reply_q  <= '0;
            nmi_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc;
            wr_q    <= wr_acc;

            // Main-CPU set takes priority over the Z80 acknowledge.
            if (CMD_WR)                    pend_q <= 1'b1;
            else if (wr_stb & dec.int_ack) pend_q <= 1'b0;

            if (CMD_WR)                  cmd_q    <= CMD_DATA;
            if (wr_stb & dec.reply)      reply_q  <= SDD_OUT;
            if (wr_stb & dec.nmi_ctl)    nmi_en_q <= SDD_OUT[0];
        end
    end

    assign nINT        = ~pend_q;
    assign CMD_PENDING = pend_q;
    assign REPLY_DATA  = reply_q;

    snd_nmi_timer #(
        .NMI_DIV   (NMI_DIV),
        .NMI_WIDTH (NMI_WIDTH)
    ) u_nmi (
        .CLK    (CLK),
        .nRESET (nRESET),
        .nmi_en (nmi_en_q),
        .nNMI   (nNMI)
    );

endmodule

// File: tb/tb_snd_bus_ctrl.sv
module tb_snd_bus_ctrl;
    localparam int WAIT_CYCLES = 2;
    localparam int NMI_DIV     = 4096;
    localparam int NMI_WIDTH   = 32;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic [15:0] SDA;
    logic [7:0]  SDD_OUT;
    logic        nMREQ, nRD, nWR;
    logic [7:0]  ROM_DQ, RAM_DQ, CHIP_DQ;
    logic [7:0]  SDD_MUX;
    logic        nROMCS, nRAMCS, nCHIPCS;
    logic        nWAIT, nINT, nNMI;
    logic        CMD_WR;
    logic [7:0]  CMD_DATA;
    logic [7:0]  REPLY_DATA;
    logic        CMD_PENDING;

    snd_bus_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .NMI_DIV     (NMI_DIV),
        .NMI_WIDTH   (NMI_WIDTH)
    ) dut (
        .CLK (CLK), .nRESET (nRESET), .SDA (SDA), .SDD_OUT (SDD_OUT),
        .nMREQ (nMREQ), .nRD (nRD), .nWR (nWR),
        .ROM_DQ (ROM_DQ), .RAM_DQ (RAM_DQ), .CHIP_DQ (CHIP_DQ),
        .SDD_MUX (SDD_MUX), .nROMCS (nROMCS), .nRAMCS (nRAMCS), .nCHIPCS (nCHIPCS),
        .nWAIT (nWAIT), .nINT (nINT), .nNMI (nNMI),
        .CMD_WR (CMD_WR), .CMD_DATA (CMD_DATA),
        .REPLY_DATA (REPLY_DATA), .CMD_PENDING (CMD_PENDING)
    );

    always #5 CLK = ~CLK;

    // Clock edges since reset release; the NMI phase reference.
    int cyc;
    always @(posedge CLK or negedge nRESET)
        if (!nRESET) cyc <= 0;
        else         cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] m_cmd, m_reply;
    logic       m_pend, m_en;

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (a < 16'hC000)      return ROM_DQ;
        else if (a < 16'hE000) return RAM_DQ;
        else if (a < 16'hE400) return CHIP_DQ;
        else if (a == 16'hF002) return m_cmd;
        else                   return 8'hFF;
    endfunction

    function automatic logic [2:0] ref_cs(input logic [15:0] a);
        return {!(a < 16'hC000), !(a >= 16'hC000 && a < 16'hE000),
                !(a >= 16'hE000 && a < 16'hE400)};
    endfunction

    function automatic int ref_waits(input logic [15:0] a);
        return (a >= 16'hE000 && a < 16'hE400) ? WAIT_CYCLES : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d,
                            output int waits, output logic [2:0] cs);
        next_cyc();
        SDA = a; nMREQ = 1'b0; nRD = 1'b0;
        #1;
        waits = 0;
        while (nWAIT === 1'b0 && waits < 20) begin
            waits++;
            next_cyc();
            #1;
        end
        d  = SDD_MUX;
        cs = {nROMCS, nRAMCS, nCHIPCS};
        next_cyc();
        nMREQ = 1'b1; nRD = 1'b1;
        next_cyc();
    endtask

    // Holds nWR low for at least 'hold' cycles (longer if waited); data on
    // SDD_OUT is inverted after the first edge so a repeated capture shows.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                             input logic cmd_also, input logic [7:0] cmd_b,
                             output int waits);
        int  n;
        bit  done;
        next_cyc();
        SDA = a; SDD_OUT = d; nMREQ = 1'b0; nWR = 1'b0;
        CMD_WR = cmd_also; CMD_DATA = cmd_b;
        #1;
        waits = 0; n = 0; done = 0;
        while (!done) begin
            if (nWAIT === 1'b0) waits++;
            n++;
            if ((n >= hold && nWAIT !== 1'b0) || n >= 20) done = 1;
            else begin
                next_cyc();
                CMD_WR = 1'b0; SDD_OUT = ~d;
                #1;
            end
        end
        next_cyc();
        CMD_WR = 1'b0; nMREQ = 1'b1; nWR = 1'b1;
        next_cyc();
    endtask

    task automatic cmd_strobe(input logic [7:0] b);
        next_cyc();
        CMD_WR = 1'b1; CMD_DATA = b;
        next_cyc();
        CMD_WR = 1'b0;
        #1;
        m_cmd = b; m_pend = 1'b1;
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  v;
        logic [2:0]  cs;
        int          w, bad, guard, region;
        int          model_pulses, obs_pulses, lows, dis_state;
        logic        pulse_en, exp_low, prev;

        nRESET = 1'b0; SDA = '0; SDD_OUT = '0;
        nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
        ROM_DQ = 8'h11; RAM_DQ = 8'h22; CHIP_DQ = 8'h33;
        CMD_WR = 1'b0; CMD_DATA = '0;
        m_cmd = '0; m_reply = '0; m_pend = 1'b0; m_en = 1'b0;

        // Reset state
        #12;
        chk("rst_nwait", nWAIT, 1);
        chk("rst_nint", nINT, 1);
        chk("rst_nnmi", nNMI, 1);
        chk("rst_pend", CMD_PENDING, 0);
        chk("rst_mux", SDD_MUX, 8'hFF);
        chk("rst_reply", REPLY_DATA, 8'h00);
        chk("rst_cs", {nROMCS, nRAMCS, nCHIPCS}, 3'b111);

        @(posedge CLK); #1;
        nRESET = 1'b1;

        // NMI disabled: no pulse over three full periods
        bad = 0;
        for (int i = 0; i < 3 * NMI_DIV + 64; i++) begin
            next_cyc();
            if (nNMI !== 1'b1) bad++;
        end
        chk("nmi_idle", bad, 0);
        chk("idle_mux", SDD_MUX, 8'hFF);

        // Directed chip and ROM reads
        CHIP_DQ = 8'hA7;
        bus_read(16'hE010, d, w, cs);
        chk("chip_waits", w, WAIT_CYCLES);
        chk("chip_data", d, 8'hA7);
        chk("chip_cs", cs, 3'b110);
        ROM_DQ = 8'h4E;
        bus_read(16'h0100, d, w, cs);
        chk("rom_waits", w, 0);
        chk("rom_data", d, 8'h4E);
        chk("rom_cs", cs, 3'b011);

        // Randomized reads across the map
        for (int i = 0; i < 24; i++) begin
            region = $urandom_range(0, 4);
            case (region)
                0:       a = 16'($urandom_range(0, 16'hBFFF));
                1:       a = 16'(16'hC000 + $urandom_range(0, 16'h1FFF));
                2:       a = 16'(16'hE000 + $urandom_range(0, 16'h03FF));
                3:       a = 16'hF002;
                default: a = 16'(16'hE400 + $urandom_range(0, 16'h0BFF));
            endcase
            ROM_DQ = 8'($urandom); RAM_DQ = 8'($urandom); CHIP_DQ = 8'($urandom);
            bus_read(a, d, w, cs);
            chk("rnd_data", d, ref_read(a));
            chk("rnd_waits", w, ref_waits(a));
            chk("rnd_cs", cs, ref_cs(a));
        end

        // Command latch handshake
        cmd_strobe(8'h5A);
        chk("cmd_nint", nINT, !m_pend);
        chk("cmd_pend", CMD_PENDING, m_pend);
        bus_read(16'hF002, d, w, cs);
        chk("cmd_rd", d, 8'h5A);
        cmd_strobe(8'hA5);
        chk("cmd2_pend", CMD_PENDING, 1);
        bus_read(16'hF002, d, w, cs);
        chk("cmd2_rd", d, 8'hA5);
        bus_write(16'hFA00, 8'h00, 1, 1'b0, 8'h00, w);
        m_pend = 1'b0;
        chk("ack_nint", nINT, 1);
        chk("ack_pend", CMD_PENDING, 0);
        cmd_strobe(8'h3C);
        bus_write(16'hFA00, 8'h00, 1, 1'b1, 8'h77, w);
        m_cmd = 8'h77; m_pend = 1'b1;
        chk("setwin_nint", nINT, 0);
        chk("setwin_pend", CMD_PENDING, 1);
        bus_read(16'hF002, d, w, cs);
        chk("setwin_rd", d, m_cmd);
        bus_write(16'hFA00, 8'h00, 1, 1'b0, 8'h00, w);
        m_pend = 1'b0;
        chk("ack2_nint", nINT, 1);

        // Reply latch, captured once over a long write
        bus_write(16'hF000, 8'hC3, 4, 1'b0, 8'h00, w);
        m_reply = 8'hC3;
        chk("reply_once", REPLY_DATA, m_reply);
        bus_read(16'hF123, d, w, cs);
        chk("unmapped_rd", d, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            bus_write(16'hF000, v, $urandom_range(1, 3), 1'b0, 8'h00, w);
            m_reply = v;
            chk("reply_rnd", REPLY_DATA, m_reply);
        end
        bus_write(16'hE005, 8'h12, 1, 1'b0, 8'h00, w);
        chk("chip_wr_waits", w, WAIT_CYCLES);
        bus_write(16'hC123, 8'h12, 1, 1'b0, 8'h00, w);
        chk("ram_wr_waits", w, 0);

        // NMI enable, then disable in the middle of the second pulse
        guard = 0;
        while ((cyc % NMI_DIV) != 100 && guard < 2 * NMI_DIV) begin
            next_cyc();
            guard++;
        end
        chk("nmi_align", guard < 2 * NMI_DIV, 1);
        bus_write(16'hFC00, 8'h01, 1, 1'b0, 8'h00, w);
        m_en = 1'b1;
        pulse_en = 1'b0; model_pulses = 0; obs_pulses = 0; lows = 0;
        bad = 0; prev = 1'b1; dis_state = 0;
        for (int i = 0; i < 3 * NMI_DIV; i++) begin
            next_cyc();
            if (dis_state == 1) begin
                nMREQ = 1'b1; nWR = 1'b1; m_en = 1'b0; dis_state = 2;
            end
            #1;
            if ((cyc % NMI_DIV) == 0) begin
                pulse_en = m_en;
                if (m_en) model_pulses++;
            end
            exp_low = pulse_en && ((cyc % NMI_DIV) < NMI_WIDTH);
            if (nNMI !== !exp_low) bad++;
            if (nNMI === 1'b0) lows++;
            if (prev && nNMI === 1'b0) obs_pulses++;
            prev = nNMI;
            if (dis_state == 0 && model_pulses == 2 && (cyc % NMI_DIV) == 10) begin
                SDA = 16'hFC00; SDD_OUT = 8'h00; nMREQ = 1'b0; nWR = 1'b0;
                dis_state = 1;
            end
        end
        chk("nmi_shape", bad, 0);
        chk("nmi_pulses", obs_pulses, model_pulses);
        chk("nmi_lows", lows, model_pulses * NMI_WIDTH);
        chk("nmi_model_cnt", model_pulses, 2);

        // Reset asserted while the FSM is holding nWAIT low
        cmd_strobe(8'h99);
        next_cyc();
        SDA = 16'hE010; nMREQ = 1'b0; nRD = 1'b0;
        #1;
        chk("pre_rst_wait0", nWAIT, 0);
        next_cyc();
        chk("pre_rst_wait1", nWAIT, 0);
        #1;
        nRESET = 1'b0;
        #1;
        chk("rst_mid_nwait", nWAIT, 1);
        chk("rst_mid_nint", nINT, 1);
        chk("rst_mid_pend", CMD_PENDING, 0);
        chk("rst_mid_reply", REPLY_DATA, 8'h00);
        nMREQ = 1'b1; nRD = 1'b1;
        next_cyc();
        nRESET = 1'b1;
        m_cmd = '0; m_pend = 1'b0; m_reply = '0; m_en = 1'b0;
        CHIP_DQ = 8'h5C;
        bus_read(16'hE3FF, d, w, cs);
        chk("post_rst_waits", w, WAIT_CYCLES);
        chk("post_rst_data", d, 8'h5C);
        bus_read(16'hF002, d, w, cs);
        chk("post_rst_cmd", d, m_cmd);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
